// File: rtl/prism_sit_bank.sv
// prism_sit_bank: double-buffered State Information Table for the PRISM engine.
// Entries are staged 32 bits at a time over the debug bus and committed whole
// into the shadow bank. The engine reads the active bank through two
// combinational ports. A bank swap is requested over the bus and happens only
// when the engine reports a safe point.
//
// Swap handshake states:
//   state   | meaning
//   SW_IDLE | no swap requested
//   SW_PEND | swap requested, waiting for swap_ok
module prism_sit_bank #(
  parameter int WIDTH     = 44,
  parameter int DEPTH     = 8,
  parameter int DUAL_BANK = 1,
  parameter int A_BITS    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        debug_addr,
  input  logic              debug_wr,
  input  logic [31:0]       debug_wdata,
  output logic [31:0]       debug_rdata,
  input  logic [A_BITS-1:0] raddr1,
  input  logic [A_BITS-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2,
  input  logic              swap_ok,
  output logic              swap_done,
  output logic              active_bank
);

  localparam int NWORDS = (WIDTH + 31) / 32;
  localparam int NBANKS = (DUAL_BANK != 0) ? 2 : 1;

  localparam logic [5:0] ADDR_WDATA = 6'h10;
  localparam logic [5:0] ADDR_CTRL  = 6'h14;
  localparam logic [5:0] ADDR_RDATA = 6'h18;
  localparam logic [5:0] ADDR_RSEL  = 6'h1C;

  typedef enum logic [0:0] {
    SW_IDLE = 1'b0,
    SW_PEND = 1'b1
  } sw_state_t;

  sw_state_t sw_state, sw_next;
  logic      do_swap;
  logic      swap_pending;

  logic [WIDTH-1:0]    mem [NBANKS][DEPTH];
  logic [31:0]         stage [NWORDS-1];
  logic [A_BITS-1:0]   wptr, rptr, wptr_inc;
  logic [1:0]          widx, rword;
  logic [5:0]          wptr_ext, rptr_ext;

  logic                wr_wdata, wr_ctrl, wr_rsel;
  logic                commit;
  logic                shadow_bank;
  logic [NWORDS*32-1:0] commit_full;
  logic [WIDTH-1:0]    commit_entry;
  logic [WIDTH-1:0]    shadow_entry;
  logic [NWORDS*32-1:0] rd_ext;
  logic [31:0]         rdata_word;
  logic                unused_bits;

  assign wr_wdata = debug_wr && (debug_addr == ADDR_WDATA);
  assign wr_ctrl  = debug_wr && (debug_addr == ADDR_CTRL);
  assign wr_rsel  = debug_wr && (debug_addr == ADDR_RSEL);

  // With one bank the shadow and the active bank are the same storage.
  assign shadow_bank  = (DUAL_BANK != 0) ? ~active_bank : 1'b0;
  assign swap_pending = (sw_state == SW_PEND);

  // The final word of an entry commits instead of staging.
  assign commit   = wr_wdata && (int'(widx) == NWORDS - 1);
  assign wptr_inc = (wptr == A_BITS'(DEPTH - 1)) ? '0 : wptr + A_BITS'(1);

  // Assemble the committed entry: staged words low, the incoming word on top.
  always_comb begin
    commit_full = '0;
    for (int i = 0; i < NWORDS - 1; i++) begin
      commit_full[i*32 +: 32] = stage[i];
    end
    commit_full[(NWORDS-1)*32 +: 32] = debug_wdata;
  end

  assign commit_entry = commit_full[WIDTH-1:0];

  // Entry storage: cleared on reset, written only by a commit into the shadow bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem[b][d] <= '0;
        end
      end
    end else if (commit && (int'(wptr) < DEPTH)) begin
      mem[shadow_bank][wptr] <= commit_entry;
    end
  end

  // Bus-visible pointers and staging words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      widx  <= '0;
      rptr  <= '0;
      rword <= '0;
      for (int i = 0; i < NWORDS - 1; i++) begin
        stage[i] <= '0;
      end
    end else begin
      if (wr_wdata) begin
        if (commit) begin
          widx <= '0;
          wptr <= wptr_inc;
        end else begin
          for (int i = 0; i < NWORDS - 1; i++) begin
            if (int'(widx) == i) begin
              stage[i] <= debug_wdata;
            end
          end
          widx <= widx + 2'd1;
        end
      end
      if (wr_ctrl) begin
        wptr <= debug_wdata[A_BITS-1:0];
        widx <= '0;
        for (int i = 0; i < NWORDS - 1; i++) begin
          stage[i] <= '0;
        end
      end
      if (wr_rsel) begin
        rptr  <= debug_wdata[A_BITS-1:0];
        rword <= debug_wdata[9:8];
      end
    end
  end

  // Swap handshake: a request registers first, the swap fires on a later swap_ok.
  always_comb begin
    sw_next = sw_state;
    do_swap = 1'b0;
    case (sw_state)
      SW_IDLE: begin
        if (wr_ctrl && debug_wdata[16]) begin
          sw_next = SW_PEND;
        end
      end
      SW_PEND: begin
        if (swap_ok) begin
          do_swap = 1'b1;
          sw_next = SW_IDLE;
        end
      end
      default: sw_next = SW_IDLE;
    endcase
  end

  // Swap state register, bank select and the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_state    <= SW_IDLE;
      swap_done   <= 1'b0;
      active_bank <= 1'b0;
    end else begin
      sw_state    <= sw_next;
      swap_done   <= do_swap;
      active_bank <= (DUAL_BANK != 0) ? (active_bank ^ do_swap) : 1'b0;
    end
  end

  // Engine read ports into the active bank.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (int'(raddr1) < DEPTH) begin
      rdata1 = mem[active_bank][raddr1];
    end
    if (int'(raddr2) < DEPTH) begin
      rdata2 = mem[active_bank][raddr2];
    end
  end

  // Debug readback of one 32-bit word of the selected shadow entry.
  always_comb begin
    shadow_entry = '0;
    if (int'(rptr) < DEPTH) begin
      shadow_entry = mem[shadow_bank][rptr];
    end
    rd_ext = '0;
    rd_ext[WIDTH-1:0] = shadow_entry;
    rdata_word = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (int'(rword) == w) begin
        rdata_word = rd_ext[w*32 +: 32];
      end
    end
  end

  // Register readback mux; unmapped and write-only addresses read as zero.
  always_comb begin
    wptr_ext = '0;
    rptr_ext = '0;
    wptr_ext[A_BITS-1:0] = wptr;
    rptr_ext[A_BITS-1:0] = rptr;
    debug_rdata = '0;
    case (debug_addr)
      ADDR_CTRL:  debug_rdata = {15'b0, swap_pending, 3'b0, active_bank,
                                 2'b0, widx, 2'b0, wptr_ext};
      ADDR_RDATA: debug_rdata = rdata_word;
      ADDR_RSEL:  debug_rdata = {22'b0, rword, 2'b0, rptr_ext};
      default:    debug_rdata = '0;
    endcase
  end

  // Bits deliberately dropped: upper bus bits, padding above WIDTH.
  assign unused_bits = ^{debug_wdata, commit_full, rd_ext};

endmodule

// File: tb/tb_prism_sit_bank.sv
// Self-checking bench for prism_sit_bank (WIDTH=44, DEPTH=8, two banks).
module tb_prism_sit_bank;

  localparam int WIDTH  = 44;
  localparam int DEPTH  = 8;
  localparam int NWORDS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  debug_addr;
  logic        debug_wr;
  logic [31:0] debug_wdata;
  logic [31:0] debug_rdata;
  logic [2:0]  raddr1, raddr2;
  logic [43:0] rdata1, rdata2;
  logic        swap_ok;
  logic        swap_done;
  logic        active_bank;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prism_sit_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DUAL_BANK(1)) dut (
    .clk(clk), .rst(rst),
    .debug_addr(debug_addr), .debug_wr(debug_wr), .debug_wdata(debug_wdata),
    .debug_rdata(debug_rdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .swap_ok(swap_ok), .swap_done(swap_done), .active_bank(active_bank)
  );

  // Reference model: banks as plain arrays, staged words as a queue.
  logic [43:0] m_bank [2][DEPTH];
  logic [31:0] m_stage [$];
  bit          m_active, m_pending, m_done;
  int          m_wptr, m_rptr, m_rword;

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int d = 0; d < DEPTH; d++) m_bank[b][d] = '0;
    m_stage.delete();
    m_active = 0; m_pending = 0; m_done = 0;
    m_wptr = 0; m_rptr = 0; m_rword = 0;
  endtask

  task automatic model_edge();
    bit sw, req;
    int sh;
    logic [63:0] e;
    if (rst) begin
      model_reset();
      return;
    end
    sw  = m_pending && swap_ok;
    sh  = m_active ? 0 : 1;
    req = 0;
    if (debug_wr) begin
      case (debug_addr)
        6'h10: begin
          if (m_stage.size() == NWORDS - 1) begin
            e = {debug_wdata, m_stage[0]};
            m_bank[sh][m_wptr] = e[43:0];
            m_wptr = (m_wptr + 1) % DEPTH;
            m_stage.delete();
          end else begin
            m_stage.push_back(debug_wdata);
          end
        end
        6'h14: begin
          m_wptr = int'(debug_wdata[5:0]) % DEPTH;
          m_stage.delete();
          req = debug_wdata[16];
        end
        6'h1C: begin
          m_rptr  = int'(debug_wdata[5:0]) % DEPTH;
          m_rword = int'(debug_wdata[9:8]);
        end
        default: ;
      endcase
    end
    if (sw) begin
      m_active  = ~m_active;
      m_pending = 0;
      m_done    = 1;
    end else begin
      m_done = 0;
      if (req) m_pending = 1;
    end
  endtask

  function automatic logic [31:0] model_readback(logic [5:0] a);
    logic [63:0] v;
    int sh;
    sh = m_active ? 0 : 1;
    case (a)
      6'h14: return {15'b0, m_pending, 3'b0, m_active, 2'b0,
                     2'(m_stage.size()), 2'b0, 6'(m_wptr)};
      6'h18: begin
        v = {20'b0, m_bank[sh][m_rptr]};
        if (m_rword < NWORDS) return v[m_rword*32 +: 32];
        return 32'h0;
      end
      6'h1C: return {22'b0, 2'(m_rword), 2'b0, 6'(m_rptr)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("rdata1", {20'b0, rdata1}, {20'b0, m_bank[m_active][raddr1]});
    check("rdata2", {20'b0, rdata2}, {20'b0, m_bank[m_active][raddr2]});
    check("active_bank", {63'b0, active_bank}, {63'b0, m_active});
    check("swap_done", {63'b0, swap_done}, {63'b0, m_done});
    if (debug_addr != 6'h10)
      check("debug_rdata", {32'b0, debug_rdata}, {32'b0, model_readback(debug_addr)});
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 ns later.
  task automatic step(input bit r, input bit wr, input logic [5:0] a,
                      input logic [31:0] wd, input bit sok,
                      input logic [2:0] ra1, input logic [2:0] ra2);
    rst = r; debug_wr = wr; debug_addr = a; debug_wdata = wd;
    swap_ok = sok; raddr1 = ra1; raddr2 = ra2;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit          r;
    bit          wr;
    logic [5:0]  a;
    logic [31:0] wd;
    bit          sok;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic [43:0] exp_r1;
    bit          exp_act;
    bit          exp_done;
  } vec_t;

  vec_t vecs [$];

  initial begin
    rst = 1'b1; debug_wr = 1'b0; debug_addr = 6'h0; debug_wdata = '0;
    swap_ok = 1'b0; raddr1 = '0; raddr2 = '0;
    model_reset();

    //             r  wr addr   wdata          sok chk exp_rd        exp_r1(ra1=3)      act done
    vecs.push_back('{1, 0, 6'h14, 32'h0,        0, 1, 32'h0,        44'h0,             0, 0});
    vecs.push_back('{0, 0, 6'h14, 32'h0,        1, 1, 32'h0,        44'h0,             0, 0});
    vecs.push_back('{0, 0, 6'h14, 32'h0,        1, 1, 32'h0,        44'h0,             0, 0});
    vecs.push_back('{0, 1, 6'h14, 32'h3,        0, 1, 32'h3,        44'h0,             0, 0});
    vecs.push_back('{0, 1, 6'h10, 32'hDEADBEEF, 0, 0, 32'h0,        44'h0,             0, 0});
    vecs.push_back('{0, 1, 6'h10, 32'hABC,      0, 0, 32'h0,        44'h0,             0, 0});
    vecs.push_back('{0, 0, 6'h14, 32'h0,        0, 1, 32'h4,        44'h0,             0, 0});
    vecs.push_back('{0, 1, 6'h1C, 32'h003,      0, 1, 32'h003,      44'h0,             0, 0});
    vecs.push_back('{0, 0, 6'h18, 32'h0,        0, 1, 32'hDEADBEEF, 44'h0,             0, 0});
    vecs.push_back('{0, 1, 6'h1C, 32'h103,      0, 1, 32'h103,      44'h0,             0, 0});
    vecs.push_back('{0, 0, 6'h18, 32'h0,        0, 1, 32'h00000ABC, 44'h0,             0, 0});
    vecs.push_back('{0, 1, 6'h14, 32'h10000,    0, 1, 32'h10000,    44'h0,             0, 0});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{0, 0, 6'h14, 32'h0,      0, 1, 32'h10000,    44'h0,             0, 0});
    vecs.push_back('{0, 0, 6'h14, 32'h0,        1, 1, 32'h1000,     44'hABC_DEADBEEF,  1, 1});
    vecs.push_back('{0, 0, 6'h14, 32'h0,        1, 1, 32'h1000,     44'hABC_DEADBEEF,  1, 0});

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].sok, 3'd3, 3'd0);
      if (vecs[i].chk_rd) check($sformatf("vec%0d debug_rdata", i), {32'b0, debug_rdata}, {32'b0, vecs[i].exp_rd});
      check($sformatf("vec%0d rdata1", i), {20'b0, rdata1}, {20'b0, vecs[i].exp_r1});
      check($sformatf("vec%0d rdata2", i), {20'b0, rdata2}, 64'h0);
      check($sformatf("vec%0d active_bank", i), {63'b0, active_bank}, {63'b0, vecs[i].exp_act});
      check($sformatf("vec%0d swap_done", i), {63'b0, swap_done}, {63'b0, vecs[i].exp_done});
    end

    // Wrap: eight entries starting at wptr=7 land at 7,0..6 of the shadow (bank 0).
    step(0, 1, 6'h14, 32'h7, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 6'h10, 32'h1000 + k, 0, 0, 0);
      step(0, 1, 6'h10, k, 0, 0, 0);
    end
    step(0, 0, 6'h14, 0, 0, 0, 0);
    check("wrap status", {32'b0, debug_rdata}, 64'h1007);
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 6'h1C, (7 + k) % 8, 0, 0, 0);
      step(0, 0, 6'h18, 0, 0, 0, 0);
      check($sformatf("wrap entry%0d", k), {32'b0, debug_rdata}, 64'h1000 + k);
    end

    // Abort: a lone staged word is discarded by a CTRL write.
    step(0, 1, 6'h14, 32'h2, 0, 0, 0);
    step(0, 1, 6'h10, 32'hFFFFFFFF, 0, 0, 0);
    step(0, 1, 6'h14, 32'h2, 0, 0, 0);
    check("abort status", {32'b0, debug_rdata}, 64'h1002);
    step(0, 1, 6'h1C, 32'h2, 0, 0, 0);
    step(0, 0, 6'h18, 0, 0, 0, 0);
    check("abort entry unchanged", {32'b0, debug_rdata}, 64'h1003);
    step(0, 1, 6'h10, 32'h55, 0, 0, 0);
    step(0, 1, 6'h10, 32'h1, 0, 0, 0);
    step(0, 0, 6'h18, 0, 0, 0, 0);
    check("post-abort word0", {32'b0, debug_rdata}, 64'h55);
    step(0, 1, 6'h1C, 32'h102, 0, 0, 0);
    step(0, 0, 6'h18, 0, 0, 0, 0);
    check("post-abort word1", {32'b0, debug_rdata}, 64'h1);

    // Collision: final commit on the same edge as the swap.
    step(0, 1, 6'h14, 32'h10005, 0, 0, 5);
    step(0, 1, 6'h10, 32'h12345678, 0, 0, 5);
    step(0, 1, 6'h10, 32'h000009AB, 1, 0, 5);
    check("collision active", {63'b0, active_bank}, 64'h0);
    check("collision done", {63'b0, swap_done}, 64'h1);
    check("collision rdata2", {20'b0, rdata2}, 64'h9AB_12345678);
    check_model();

    // Reset mid-entry clears both banks and the bank select.
    step(0, 1, 6'h10, 32'h1111, 0, 0, 0);
    step(1, 0, 6'h14, 0, 0, 0, 0);
    step(0, 0, 6'h14, 0, 0, 0, 0);
    check("rst status", {32'b0, debug_rdata}, 64'h0);
    check("rst active", {63'b0, active_bank}, 64'h0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 6'h1C, i, 0, 3'(i), 3'(i));
      check($sformatf("rst active bank%0d", i), {20'b0, rdata1}, 64'h0);
      step(0, 0, 6'h18, 0, 0, 3'(i), 3'(i));
      check($sformatf("rst shadow bank%0d", i), {32'b0, debug_rdata}, 64'h0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit r, wr, sok;
      logic [5:0] a;
      logic [31:0] wd;
      int sel;
      r   = ($urandom_range(0, 299) == 0);
      wr  = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = 6'h10;
        4, 5:       a = 6'h14;
        6:          a = 6'h1C;
        7, 8:       a = 6'h18;
        default:    a = 6'($urandom());
      endcase
      wd = $urandom();
      if (a == 6'h14) wd[16] = ($urandom_range(0, 3) == 0);
      sok = ($urandom_range(0, 3) == 0);
      step(r, wr, a, wd, sok, 3'($urandom()), 3'($urandom()));
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prism_sit_bank.md
# prism_sit_bank

Double-buffered, randomly addressable State Information Table for the PRISM engine. It replaces shift-in programming with pointer-addressed, multi-word staged writes over the 32-bit debug bus. It has two asynchronous read ports for the state machine, and a shadow bank that can be reprogrammed while the active bank keeps executing. A bank swap is requested over the bus and takes effect only when the engine signals a safe point.

## Interface
- WIDTH, default 44: stew width in bits. Legal range 33..128.
- DEPTH, default 8: entries per bank. Legal range 2..64.
- DUAL_BANK, default 1: 1 gives two banks (active + shadow); 0 gives a single bank that is both active and shadow.
- A_BITS, default ceil(log2(DEPTH)) (min 1): entry address width.
- NWORDS, derived, ceil(WIDTH/32): bus words per entry (2..4).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- debug_addr  in  6  peripheral register address.
- debug_wr  in  1  active-high write strobe, one cycle per write.
- debug_wdata  in  32  write data.
- debug_rdata  out  32  combinational readback selected by debug_addr.
- raddr1, raddr2  in  A_BITS  read addresses into the active bank.
- rdata1, rdata2  out  WIDTH  combinational entry data from the active bank.
- swap_ok  in  1  engine is at a safe point; a pending swap may occur.
- swap_done  out  1  one-cycle pulse in the cycle after a swap.
- active_bank  out  1  current active bank (always 0 when DUAL_BANK=0).

## Operation
- Registers:
  - 0x10 WDATA.
  - 0x14 CTRL/STATUS.
  - 0x18 RDATA (read only).
  - 0x1C RSEL.
- Writes to any other address are ignored; reads of other addresses return 0.
- WDATA write:
  - Stores debug_wdata into staging word widx; widx increments.
  - When widx==NWORDS-1, the write instead commits {this word, staged words} to shadow[wptr]. Word 0 is the LSBs.
  - On commit, widx returns to 0 and wptr increments, wrapping DEPTH-1→0.
  - Bits of the last word above WIDTH are discarded.
- CTRL write:
  - [5:0] loads wptr; only the low A_BITS are used.
  - widx is cleared and staging data is discarded.
  - [16]=1 sets swap_pending.
- STATUS read (0x14): {15'b0, swap_pending[16], 3'b0, active_bank[12], 2'b0, widx[9:8], 2'b0, wptr zero-extended[5:0]}.
- RSEL write: [5:0] loads rptr (low A_BITS used) and [9:8] loads rword. An rword value ≥NWORDS reads as 0. A read of 0x1C returns the same field layout.
- RDATA read: word rword of shadow[rptr], with bits above WIDTH zeroed.
- Swap:
  - If swap_pending && swap_ok at a clock edge, active_bank toggles, swap_pending clears, and swap_done is 1 in the following cycle.
  - With DUAL_BANK=0 the swap performs the same handshake, but active_bank stays 0.
- Shadow bank = ~active_bank when DUAL_BANK=1; otherwise bank 0.

## Timing
- Reset values:
  - All entries of both banks are 0.
  - Staging registers, wptr, widx, rptr, rword = 0.
  - swap_pending = 0, active_bank = 0, swap_done = 0.
  - Therefore rdata1/rdata2 = 0 and debug_rdata = 0 for unused addresses.
- A rst asserted mid-sequence aborts any partial entry and any pending swap. No partial commit occurs.
- Commit latency: the entry is written at the edge of the final WDATA write.
  - Visible on RDATA the next cycle.
  - Visible on rdata1/2 the next cycle only if DUAL_BANK=0; otherwise only after a swap.
- Swap request and swap_ok in the same cycle as the CTRL write: pending registers first, so the swap happens at the earliest one edge later.
- A further swap request while pending is absorbed; exactly one swap occurs.
- Commit in the same cycle as a swap: the commit targets the pre-swap shadow bank, which becomes active. Entry and swap are both visible next cycle.
- A CTRL write in the same cycle as a WDATA write is impossible (single address); no arbitration is required.
- Reads are fully combinational; there is no read latency.

## Test plan
- Reset with WIDTH=44, DEPTH=8:
  - rdata1/2 = 0.
  - STATUS = 0.
  - A swap with swap_ok=1 and no request leaves active_bank=0 and swap_done=0.
- Program shadow[3]:
  - Stimulus: CTRL=0x3, WDATA=0xDEADBEEF, WDATA=0xABC.
  - STATUS reads wptr=4, widx=0.
  - RSEL=0x003 → RDATA=0xDEADBEEF.
  - RSEL=0x103 → RDATA=0x00000ABC.
  - rdata1(raddr1=3) = 0 before the swap.
- Swap handshake:
  - Stimulus: CTRL=0x10000 with swap_ok=0 for 5 cycles, then 1.
  - pending=1 until the swap_ok edge.
  - active_bank=1 and swap_done pulses for exactly 1 cycle.
  - rdata1(3) = 44'hABC_DEADBEEF.
- Wrap and abort:
  - 8 full entries from wptr=7 → wptr wraps to 7; the first entry lands at 7, then 0..6.
  - A single WDATA followed by a CTRL write discards the staged word (widx=0, entry unchanged).
- Collision:
  - Final WDATA commit in the same cycle as swap_ok with pending=1 → the next cycle shows the new entry on rdata2 from the newly active bank.
  - A rst pulse mid-entry zeroes both banks and leaves active_bank=0.
